hv_stream_packer: RTL and testbench

// - Downstream of the HV core. Captures each stored hypervector (store/core_result/last)

---
 rtl/hv_stream_packer_if.sv | 29 ++
 rtl/hv_stream_packer.sv | 102 ++++++++++
 tb/tb_hv_stream_packer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/hv_stream_packer_if.sv
// Stream packer bus: core store side in, word stream and FIFO status out.
interface hv_stream_packer_if #(
    parameter int unsigned DIM   = 1023,
    parameter int unsigned OUT_W = 32
);
    logic             run;
    logic             store;
    logic [DIM:0]     core_result;
    logic             last;
    logic             stream_ready;
    logic             stream_v;
    logic [OUT_W-1:0] stream_d;
    logic             stream_last;
    logic             full;
    logic             empty;
    logic             overflow;

    // Packer side
    modport slave (
        input  run, store, core_result, last, stream_ready,
        output stream_v, stream_d, stream_last, full, empty, overflow
    );

    // Core / downstream side
    modport master (
        output run, store, core_result, last, stream_ready,
        input  stream_v, stream_d, stream_last, full, empty, overflow
    );
endinterface

// File: rtl/hv_stream_packer.sv
// Captures stored hypervectors into a small HV-wide FIFO and serializes each one
// into OUT_W-bit words on a valid/ready stream, word 0 first.
module hv_stream_packer #(
    parameter int unsigned DIM   = 1023,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    hv_stream_packer_if.slave   bus_io
);
    localparam int unsigned NW   = (DIM + 1) / OUT_W;
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned IdxW = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned EntW = DIM + 2;

    logic [EntW-1:0] mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [IdxW-1:0] word_idx_q, word_idx_d;
    logic            overflow_q, overflow_d;

    logic [EntW-1:0]  head;
    logic [OUT_W-1:0] head_word;
    logic             valid, full, last_word, xfer, pop, push, drop;

    // Handshake and FIFO event decode
    always_comb begin
        head      = mem_q[rd_ptr_q];
        head_word = head[word_idx_q * OUT_W +: OUT_W];
        valid     = (count_q != '0);
        full      = (count_q == CntW'(DEPTH));
        last_word = (word_idx_q == IdxW'(NW - 1));
        xfer      = valid & bus_io.stream_ready;
        pop       = xfer & last_word;
        // A pop frees the head slot this edge, so a store is accepted even when full
        push      = bus_io.run & bus_io.store & (~full | pop);
        drop      = bus_io.run & bus_io.store & full & ~pop;
    end

    // Next-state for pointers, occupancy, word index and sticky overflow
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        overflow_d = overflow_q;
        if (!bus_io.run) begin
            // Synchronous flush: any partial HV is discarded
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            word_idx_d = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + PtrW'(1);
                word_idx_d = '0;
            end else if (xfer) begin
                word_idx_d = word_idx_q + IdxW'(1);
            end
            if (push && !pop) count_d = count_q + CntW'(1);
            else if (pop && !push) count_d = count_q - CntW'(1);
            if (drop) overflow_d = 1'b1;
        end
    end

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            word_idx_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            overflow_q <= overflow_d;
        end
    end

    // HV storage; contents need no reset since reads are qualified by count
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus_io.last, bus_io.core_result};
    end

    // Outputs; word select reads registered storage so no extra latency is added
    always_comb begin
        bus_io.stream_v    = valid;
        bus_io.stream_d    = valid ? head_word : '0;
        bus_io.stream_last = valid & head[EntW-1] & last_word;
        bus_io.full        = full;
        bus_io.empty       = ~valid;
        bus_io.overflow    = overflow_q;
    end
endmodule

// File: tb/tb_hv_stream_packer.sv
// Directed bench for hv_stream_packer: single HV, last tag, backpressure, burst/drop,
// push+pop when full, flush and async reset.
module tb_hv_stream_packer;
    localparam int unsigned DIM   = 1023;
    localparam int unsigned OUT_W = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned NW    = (DIM + 1) / OUT_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hv_stream_packer_if #(.DIM(DIM), .OUT_W(OUT_W)) bus ();

    hv_stream_packer #(.DIM(DIM), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [DIM:0] make_hv(input logic [31:0] base);
        logic [DIM:0] hv;
        hv = '0;
        for (int k = 0; k < NW; k++) hv[k*OUT_W +: OUT_W] = base + 32'(k);
        return hv;
    endfunction

    // Called at a negedge; drives store for one edge and returns at the next negedge
    task automatic push_hv(input logic [31:0] base, input logic lst);
        bus.store       = 1'b1;
        bus.core_result = make_hv(base);
        bus.last        = lst;
        @(negedge clk);
        bus.store = 1'b0;
        bus.last  = 1'b0;
    endtask

    // Expects NW consecutive valid words of one HV with ready held high
    task automatic drain_hv(input logic [31:0] base, input logic lst, input string tag);
        bus.stream_ready = 1'b1;
        for (int i = 0; i < NW; i++) begin
            check_eq({tag, "_v"}, 64'(bus.stream_v), 64'd1);
            check_eq({tag, "_d"}, 64'(bus.stream_d), 64'(base + 32'(i)));
            check_eq({tag, "_last"}, 64'(bus.stream_last), 64'(lst && (i == NW - 1)));
            @(negedge clk);
        end
    endtask

    initial begin
        int idx;
        logic r;
        rst              = 1'b1;
        bus.run          = 1'b0;
        bus.store        = 1'b0;
        bus.last         = 1'b0;
        bus.core_result  = '0;
        bus.stream_ready = 1'b0;
        #12;
        check_eq("rst_v", 64'(bus.stream_v), 64'd0);
        check_eq("rst_empty", 64'(bus.empty), 64'd1);
        check_eq("rst_full", 64'(bus.full), 64'd0);
        check_eq("rst_ovf", 64'(bus.overflow), 64'd0);
        check_eq("rst_last", 64'(bus.stream_last), 64'd0);
        check_eq("rst_d", 64'(bus.stream_d), 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        bus.run = 1'b1;
        @(negedge clk);

        // T1 single HV
        bus.stream_ready = 1'b1;
        check_eq("t1_pre_v", 64'(bus.stream_v), 64'd0);
        push_hv(32'hA500_0000, 1'b0);
        drain_hv(32'hA500_0000, 1'b0, "t1");
        check_eq("t1_empty", 64'(bus.empty), 64'd1);
        check_eq("t1_v_done", 64'(bus.stream_v), 64'd0);

        // T2 last tag
        push_hv(32'hB600_0000, 1'b1);
        drain_hv(32'hB600_0000, 1'b1, "t2");
        check_eq("t2_last_after", 64'(bus.stream_last), 64'd0);
        check_eq("t2_empty", 64'(bus.empty), 64'd1);

        // T3 backpressure, ready pattern 1,0,0,1
        bus.stream_ready = 1'b0;
        push_hv(32'hC700_0000, 1'b0);
        idx = 0;
        for (int cyc = 0; cyc < 200 && idx < NW; cyc++) begin
            r = (cyc % 4 == 0) || (cyc % 4 == 3);
            check_eq("t3_v", 64'(bus.stream_v), 64'd1);
            check_eq("t3_d", 64'(bus.stream_d), 64'(32'hC700_0000 + 32'(idx)));
            check_eq("t3_last", 64'(bus.stream_last), 64'd0);
            bus.stream_ready = r;
            if (r) idx++;
            @(negedge clk);
        end
        bus.stream_ready = 1'b0;
        check_eq("t3_empty", 64'(bus.empty), 64'd1);
        check_eq("t3_v_done", 64'(bus.stream_v), 64'd0);

        // T4 burst of 3 stores with ready low
        bus.store       = 1'b1;
        bus.core_result = make_hv(32'hD000_0000);
        @(negedge clk);
        check_eq("t4_full1", 64'(bus.full), 64'd0);
        bus.core_result = make_hv(32'hD100_0000);
        @(negedge clk);
        check_eq("t4_full2", 64'(bus.full), 64'd1);
        check_eq("t4_ovf2", 64'(bus.overflow), 64'd0);
        bus.core_result = make_hv(32'hD200_0000);
        @(negedge clk);
        bus.store = 1'b0;
        check_eq("t4_ovf3", 64'(bus.overflow), 64'd1);
        check_eq("t4_full3", 64'(bus.full), 64'd1);
        drain_hv(32'hD000_0000, 1'b0, "t4a");
        drain_hv(32'hD100_0000, 1'b0, "t4b");
        check_eq("t4_empty", 64'(bus.empty), 64'd1);
        check_eq("t4_ovf_sticky", 64'(bus.overflow), 64'd1);
        bus.run = 1'b0;
        @(negedge clk);
        bus.run = 1'b1;
        check_eq("t4_ovf_flush", 64'(bus.overflow), 64'd0);

        // T5 push coinciding with pop while full
        bus.stream_ready = 1'b0;
        push_hv(32'hE000_0000, 1'b0);
        push_hv(32'hE100_0000, 1'b0);
        check_eq("t5_full", 64'(bus.full), 64'd1);
        bus.stream_ready = 1'b1;
        for (int i = 0; i < NW; i++) begin
            check_eq("t5_d", 64'(bus.stream_d), 64'(32'hE000_0000 + 32'(i)));
            if (i == NW - 1) begin
                bus.store       = 1'b1;
                bus.core_result = make_hv(32'hE200_0000);
            end
            @(negedge clk);
        end
        bus.store = 1'b0;
        check_eq("t5_ovf", 64'(bus.overflow), 64'd0);
        check_eq("t5_full_after", 64'(bus.full), 64'd1);
        drain_hv(32'hE100_0000, 1'b0, "t5b");
        drain_hv(32'hE200_0000, 1'b0, "t5c");
        check_eq("t5_empty", 64'(bus.empty), 64'd1);

        // T6 flush mid-HV, with overflow set beforehand
        bus.stream_ready = 1'b0;
        push_hv(32'hF000_0000, 1'b0);
        push_hv(32'hF100_0000, 1'b0);
        push_hv(32'hF200_0000, 1'b0);
        check_eq("t6_ovf_set", 64'(bus.overflow), 64'd1);
        bus.stream_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_eq("t6_d", 64'(bus.stream_d), 64'(32'hF000_0000 + 32'(i)));
            @(negedge clk);
        end
        check_eq("t6_d10", 64'(bus.stream_d), 64'(32'hF000_000A));
        bus.run = 1'b0;
        @(negedge clk);
        check_eq("t6_v", 64'(bus.stream_v), 64'd0);
        check_eq("t6_empty", 64'(bus.empty), 64'd1);
        check_eq("t6_ovf", 64'(bus.overflow), 64'd0);
        check_eq("t6_full", 64'(bus.full), 64'd0);
        bus.run          = 1'b1;
        bus.stream_ready = 1'b0;
        @(negedge clk);

        // Async reset mid-cycle
        push_hv(32'h1234_0000, 1'b1);
        check_eq("ar_v_pre", 64'(bus.stream_v), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_v", 64'(bus.stream_v), 64'd0);
        check_eq("ar_empty", 64'(bus.empty), 64'd1);
        check_eq("ar_d", 64'(bus.stream_d), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ar_v_post", 64'(bus.stream_v), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
